// File: rtl/mem_access_unit.sv
// mem_access_unit: RV32I/RV64I load/store unit between the MEM stage and a handshaked data bus.
// Optional feature: define LSU_MISALIGNED_EN to perform misaligned accesses in one or two beats.
module mem_access_unit #(
    parameter int XLEN        = 32,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_misaligned,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_be,
    input  logic              mem_ack,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_err
);
    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam int CNTW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam bit TMO_EN = (TIMEOUT_CYC > 0);
`ifdef LSU_MISALIGNED_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;
    state_t state, state_next;

    logic              we_q;
    logic [2:0]        f3_q;
    logic [OFFW-1:0]   off_q;
    logic              split_q;
    logic [NB-1:0]     be_hi_q;
    logic [XLEN-1:0]   wd_hi_q;
    logic [XLEN-1:0]   lo_q;
    logic [CNTW-1:0]   cnt;

    logic              accept;
    logic              illegal;
    logic              misal;
    logic              trap;
    logic              split;
    logic [2:0]        lowmask;
    logic [NB-1:0]     szmask;
    logic [XLEN-1:0]   wmask;
    logic [2*NB-1:0]   be2;
    logic [2*XLEN-1:0] wd2;
    logic [ADDR_W-1:0] word_addr;
    logic              tmo_fire;
    logic              beat_done;
    logic              beat_split;
    logic [2*XLEN-1:0] rd2;
    logic [XLEN-1:0]   ld_val;

    // Sign- or zero-extend the low (8 << f3[1:0]) bits of raw to XLEN.
    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] raw, input logic [2:0] f3);
        int sh;
        logic [XLEN-1:0] t;
        sh = XLEN - (8 << f3[1:0]);
        if (sh < 0) sh = 0;
        t = raw << sh;
        if (f3[2]) return t >> sh;
        return XLEN'($signed(t) >>> sh);
    endfunction

    // Decode the incoming request: legality, alignment and lane steering over two words.
    always_comb begin
        illegal = (req_funct3 == 3'b111) || (req_we && req_funct3[2]);
        if (XLEN == 32 && (req_funct3[1:0] == 2'b11 || req_funct3 == 3'b110))
            illegal = 1'b1;
        lowmask = '0;
        szmask  = '0;
        unique case (req_funct3[1:0])
            2'b00: begin lowmask = 3'b000; szmask = NB'(8'h01); end
            2'b01: begin lowmask = 3'b001; szmask = NB'(8'h03); end
            2'b10: begin lowmask = 3'b011; szmask = NB'(8'h0F); end
            2'b11: begin lowmask = 3'b111; szmask = NB'(8'hFF); end
        endcase
        misal = |(req_addr[2:0] & lowmask);
        trap  = misal & ~MIS_EN;
        wmask = '0;
        for (int i = 0; i < NB; i++) wmask[8*i +: 8] = {8{szmask[i]}};
        be2 = {{NB{1'b0}}, szmask} << req_addr[OFFW-1:0];
        wd2 = {{XLEN{1'b0}}, req_wdata & wmask} << {req_addr[OFFW-1:0], 3'b000};
        split = |be2[2*NB-1:NB];
        word_addr = {req_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        mem_req    = 1'b0;
        rsp_valid  = 1'b0;
        busy       = (state != IDLE);
        accept     = 1'b0;
        beat_done  = 1'b0;
        beat_split = 1'b0;
        tmo_fire   = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = ~rst;
                accept    = req_valid & ~rst;
                if (accept) state_next = (illegal || trap) ? RESP : BEAT0;
            end
            BEAT0, BEAT1: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    if (state == BEAT0 && split_q && !mem_err) begin
                        beat_split = 1'b1;
                        state_next = BEAT1;
                    end else begin
                        beat_done  = 1'b1;
                        state_next = RESP;
                    end
                end else if (TMO_EN && cnt == CNT_LAST) begin
                    tmo_fire   = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Assemble the addressed bytes from one or two read beats and extend them.
    always_comb begin
        rd2    = (state == BEAT1) ? {mem_rdata, lo_q} : {{XLEN{1'b0}}, mem_rdata};
        ld_val = extend(XLEN'(rd2 >> {off_q, 3'b000}), f3_q);
    end

    // Request capture, beat sequencing, timeout counting and response formatting.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q           <= 1'b0;
            f3_q           <= '0;
            off_q          <= '0;
            split_q        <= 1'b0;
            be_hi_q        <= '0;
            wd_hi_q        <= '0;
            lo_q           <= '0;
            cnt            <= '0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            mem_be         <= '0;
            rsp_rdata      <= '0;
            rsp_err        <= 1'b0;
            rsp_misaligned <= 1'b0;
        end else begin
            if (accept) begin
                we_q      <= req_we;
                f3_q      <= req_funct3;
                off_q     <= req_addr[OFFW-1:0];
                split_q   <= split;
                be_hi_q   <= be2[2*NB-1:NB];
                wd_hi_q   <= req_we ? wd2[2*XLEN-1:XLEN] : '0;
                mem_we    <= req_we;
                mem_addr  <= word_addr;
                mem_be    <= be2[NB-1:0];
                mem_wdata <= req_we ? wd2[XLEN-1:0] : '0;
                cnt       <= '0;
                if (illegal || trap) begin
                    rsp_rdata      <= '0;
                    rsp_err        <= illegal;
                    rsp_misaligned <= ~illegal;
                end
            end
            if (mem_req) cnt <= mem_ack ? '0 : cnt + CNTW'(1);
            if (beat_split) begin
                lo_q      <= mem_rdata;
                mem_addr  <= mem_addr + ADDR_W'(NB);
                mem_be    <= be_hi_q;
                mem_wdata <= wd_hi_q;
            end
            if (beat_done) begin
                rsp_err        <= mem_err;
                rsp_misaligned <= 1'b0;
                rsp_rdata      <= (we_q || mem_err) ? '0 : ld_val;
            end
            if (tmo_fire) begin
                rsp_err        <= 1'b1;
                rsp_misaligned <= 1'b0;
                rsp_rdata      <= '0;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and randomized checks of mem_access_unit (XLEN=32, TIMEOUT_CYC=4)
// against a byte-level reference model; honours LSU_MISALIGNED_EN when defined.
module tb_mem_access_unit;
    localparam int TMO = 4;
`ifdef LSU_MISALIGNED_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    typedef struct {
        bit        we;
        bit [2:0]  f3;
        bit [31:0] addr;
        bit [31:0] wd;
        bit [31:0] rd0;
        bit [31:0] rd1;
        int        w0;
        int        w1;
        bit        e0;
        bit        e1;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_misaligned;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_err = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    int          o_nbeats, o_req, o_cyc;
    logic        o_ready, o_err, o_mis;
    logic [31:0] o_rdata;
    logic [31:0] o_addr[2];
    logic [31:0] o_wd[2];
    logic [3:0]  o_be[2];
    logic        o_we[2];

    int          e_nbeats, e_req, e_cyc;
    logic        e_err, e_mis;
    logic [31:0] e_rdata;
    logic [31:0] e_addr[2];
    logic [31:0] e_wd[2];
    logic [3:0]  e_be[2];

    mem_access_unit #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_misaligned(rsp_misaligned), .busy(busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    // Drive one request and act as the bus slave; record what is observed.
    task automatic run_txn(input vec_t v);
        int beat, wleft, cyc;
        bit done;
        o_nbeats = 0; o_req = 0; o_cyc = -1;
        o_err = 1'bx; o_mis = 1'bx; o_rdata = 'x;
        for (int i = 0; i < 2; i++) begin
            o_addr[i] = '0; o_wd[i] = '0; o_be[i] = '0; o_we[i] = 1'b0;
        end
        @(negedge clk);
        o_ready = req_ready;
        req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3;
        req_addr = v.addr; req_wdata = v.wd;
        @(negedge clk);
        req_valid = 1'b0;
        beat = 0; wleft = v.w0; cyc = 1; done = 0;
        while (!done && cyc < 40) begin
            mem_ack = 1'b0; mem_err = 1'b0; mem_rdata = '0;
            if (rsp_valid) begin
                o_cyc = cyc; o_rdata = rsp_rdata;
                o_err = rsp_err; o_mis = rsp_misaligned;
                done = 1;
            end else if (mem_req) begin
                o_req++;
                if (wleft == 0) begin
                    mem_ack = 1'b1;
                    mem_rdata = (beat == 0) ? v.rd0 : v.rd1;
                    mem_err = (beat == 0) ? v.e0 : v.e1;
                    if (beat < 2) begin
                        o_addr[beat] = mem_addr; o_be[beat] = mem_be;
                        o_wd[beat] = mem_wdata; o_we[beat] = mem_we;
                    end
                    o_nbeats++; beat++; wleft = v.w1;
                end else begin
                    wleft--;
                end
            end
            if (!done) begin
                @(negedge clk);
                cyc++;
            end
        end
        mem_ack = 1'b0; mem_err = 1'b0;
    endtask

    // Byte-by-byte reference of the expected bus beats and response.
    task automatic model(input vec_t v);
        int size, b, lane;
        bit illegal, mis, split;
        logic [31:0] first, a;
        longint val;
        size = 1 << v.f3[1:0];
        illegal = (v.f3 == 3'b111) || (v.we && v.f3[2]) ||
                  (v.f3[1:0] == 2'b11) || (v.f3 == 3'b110);
        mis = (v.addr % size) != 0;
        e_nbeats = 0; e_req = 0; e_err = 0; e_mis = 0; e_rdata = '0;
        for (int i = 0; i < 2; i++) begin
            e_addr[i] = '0; e_wd[i] = '0; e_be[i] = '0;
        end
        if (illegal) begin
            e_err = 1;
        end else if (mis && !MIS_EN) begin
            e_mis = 1;
        end else begin
            first = v.addr & ~32'd3;
            split = ((v.addr + size - 1) & ~32'd3) != first;
            e_addr[0] = first; e_addr[1] = first + 32'd4;
            val = 0;
            for (int i = 0; i < size; i++) begin
                a = v.addr + i;
                lane = a % 4;
                b = ((a & ~32'd3) == first) ? 0 : 1;
                e_be[b][lane] = 1'b1;
                e_wd[b] |= ((v.wd >> (8 * i)) & 32'hFF) << (8 * lane);
                val |= longint'(((b != 0 ? v.rd1 : v.rd0) >> (8 * lane)) & 32'hFF) << (8 * i);
            end
            if (!v.f3[2] && ((val >> (8 * size - 1)) & 1) != 0)
                val = val - (longint'(1) << (8 * size));
            if (v.w0 >= TMO) begin
                e_req = TMO; e_err = 1;
            end else begin
                e_nbeats = 1; e_req = v.w0 + 1; e_err = v.e0;
                if (split && !v.e0) begin
                    if (v.w1 >= TMO) begin
                        e_req += TMO; e_err = 1;
                    end else begin
                        e_nbeats = 2; e_req += v.w1 + 1; e_err = v.e1;
                    end
                end
            end
            e_rdata = (v.we || e_err) ? 32'd0 : val[31:0];
        end
        e_cyc = 1 + e_req;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready_low: got %b expected 0", req_ready);
        end
        n_checks++;
        if ({mem_req, mem_we, rsp_valid, rsp_err, rsp_misaligned, busy} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {mem_req, mem_we, rsp_valid, rsp_err, rsp_misaligned, busy});
        end
        n_checks++;
        if ({rsp_rdata, mem_addr, mem_wdata, mem_be} !== 100'b0) begin
            n_fail++;
            $display("FAIL reset_data: got %h %h %h %h expected all 0",
                     rsp_rdata, mem_addr, mem_wdata, mem_be);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready_high: got %b expected 1", req_ready);
        end
    endtask

    // Directed vectors followed by back-to-back random ones.
    task automatic test_accesses();
        vec_t dir[14];
        vec_t v;
        dir[0]  = '{1'b1, 3'b010, 32'h1000, 32'hDEADBEEF, 0, 0, 0, 0, 1'b0, 1'b0};
        dir[1]  = '{1'b0, 3'b000, 32'h1003, 0, 32'h80FFFFFF, 0, 0, 0, 1'b0, 1'b0};
        dir[2]  = '{1'b0, 3'b100, 32'h1003, 0, 32'h80FFFFFF, 0, 0, 0, 1'b0, 1'b0};
        dir[3]  = '{1'b0, 3'b101, 32'h1002, 0, 32'h80FFFFFF, 0, 0, 0, 1'b0, 1'b0};
        dir[4]  = '{1'b0, 3'b010, 32'h1002, 0, 32'h44332211, 32'h88776655, 0, 0, 1'b0, 1'b0};
        dir[5]  = '{1'b1, 3'b001, 32'h1003, 32'h0000ABCD, 0, 0, 0, 0, 1'b0, 1'b0};
        dir[6]  = '{1'b0, 3'b011, 32'h1000, 0, 0, 0, 0, 0, 1'b0, 1'b0};
        dir[7]  = '{1'b0, 3'b010, 32'h1008, 0, 32'h12345678, 0, 1, 0, 1'b1, 1'b0};
        dir[8]  = '{1'b1, 3'b010, 32'h1001, 32'h01020304, 0, 0, 0, 1, 1'b0, 1'b1};
        dir[9]  = '{1'b0, 3'b010, 32'hFFFFFFFE, 0, 32'hA1B2C3D4, 32'h55667788, 0, 0, 1'b0, 1'b0};
        dir[10] = '{1'b1, 3'b100, 32'h1000, 32'h11111111, 0, 0, 0, 0, 1'b0, 1'b0};
        dir[11] = '{1'b0, 3'b001, 32'h1001, 0, 32'hCAFE8001, 0, 2, 0, 1'b0, 1'b0};
        dir[12] = '{1'b0, 3'b010, 32'h100C, 0, 32'h87654321, 0, 3, 0, 1'b0, 1'b0};
        dir[13] = '{1'b0, 3'b111, 32'h1000, 0, 0, 0, 0, 0, 1'b0, 1'b0};
        for (int k = 0; k < 74; k++) begin
            if (k < 14) begin
                v = dir[k];
            end else begin
                v.we   = 1'($urandom_range(0, 1));
                v.f3   = 3'($urandom_range(0, 7));
                v.addr = (($urandom_range(0, 7) == 0) ? 32'hFFFFFFF8 : 32'h2000)
                         + 32'($urandom_range(0, 7));
                v.wd   = $urandom;
                v.rd0  = $urandom;
                v.rd1  = $urandom;
                v.w0   = $urandom_range(0, 3);
                v.w1   = $urandom_range(0, 3);
                v.e0   = ($urandom_range(0, 9) == 0);
                v.e1   = ($urandom_range(0, 9) == 0);
            end
            model(v);
            run_txn(v);
            n_checks++;
            if (o_ready !== 1'b1) begin
                n_fail++; $display("FAIL ready[%0d]: got %b expected 1", k, o_ready);
            end
            n_checks++;
            if (o_cyc != e_cyc) begin
                n_fail++; $display("FAIL latency[%0d]: got %0d expected %0d", k, o_cyc, e_cyc);
            end
            n_checks++;
            if (o_req != e_req || o_nbeats != e_nbeats) begin
                n_fail++;
                $display("FAIL bus_cycles[%0d]: got req=%0d beats=%0d expected req=%0d beats=%0d",
                         k, o_req, o_nbeats, e_req, e_nbeats);
            end
            n_checks++;
            if (o_err !== e_err || o_mis !== e_mis) begin
                n_fail++;
                $display("FAIL rsp_flags[%0d]: got err=%b mis=%b expected err=%b mis=%b",
                         k, o_err, o_mis, e_err, e_mis);
            end
            n_checks++;
            if (o_rdata !== e_rdata) begin
                n_fail++; $display("FAIL rsp_rdata[%0d]: got %h expected %h", k, o_rdata, e_rdata);
            end
            for (int b = 0; b < e_nbeats; b++) begin
                n_checks++;
                if (o_addr[b] !== e_addr[b] || o_we[b] !== v.we) begin
                    n_fail++;
                    $display("FAIL beat%0d_addr[%0d]: got %h we=%b expected %h we=%b",
                             b, k, o_addr[b], o_we[b], e_addr[b], v.we);
                end
                if (v.we) begin
                    n_checks++;
                    if (o_be[b] !== e_be[b] || o_wd[b] !== e_wd[b]) begin
                        n_fail++;
                        $display("FAIL beat%0d_wr[%0d]: got be=%b wd=%h expected be=%b wd=%h",
                                 b, k, o_be[b], o_wd[b], e_be[b], e_wd[b]);
                    end
                end
            end
        end
    endtask

    task automatic test_timeout();
        vec_t v;
        v = '{1'b0, 3'b010, 32'h3000, 0, 32'h12345678, 0, 100, 0, 1'b0, 1'b0};
        run_txn(v);
        n_checks++;
        if (o_req != 4 || o_cyc != 5 || o_nbeats != 0) begin
            n_fail++;
            $display("FAIL timeout_cycles: got req=%0d rsp=%0d beats=%0d expected 4 5 0",
                     o_req, o_cyc, o_nbeats);
        end
        n_checks++;
        if (o_err !== 1'b1 || o_rdata !== 32'd0) begin
            n_fail++; $display("FAIL timeout_rsp: got err=%b rdata=%h expected 1 0", o_err, o_rdata);
        end
        v.w0 = 3;
        run_txn(v);
        n_checks++;
        if (o_req != 4 || o_cyc != 5 || o_err !== 1'b0 || o_rdata !== 32'h12345678) begin
            n_fail++;
            $display("FAIL ack_at_expiry: got req=%0d rsp=%0d err=%b rdata=%h expected 4 5 0 12345678",
                     o_req, o_cyc, o_err, o_rdata);
        end
    endtask

    task automatic test_hold();
        vec_t v;
        v = '{1'b0, 3'b101, 32'h4002, 0, 32'hBEEF0000, 0, 0, 0, 1'b0, 1'b0};
        run_txn(v);
        repeat (3) @(negedge clk);
        n_checks++;
        if (rsp_rdata !== 32'h0000BEEF || rsp_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rdata_hold: got rdata=%h valid=%b busy=%b expected 0000beef 0 0",
                     rsp_rdata, rsp_valid, busy);
        end
    endtask

    task automatic test_reset_abort();
        bit seen;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'h5000; req_wdata = '0;
        @(negedge clk);
        req_valid = 1'b0;
        n_checks++;
        if (mem_req !== 1'b1) begin
            n_fail++; $display("FAIL abort_req_start: got %b expected 1", mem_req);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_in_reset: got req=%b valid=%b ready=%b expected 0 0 0",
                     mem_req, rsp_valid, req_ready);
        end
        rst = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        mem_ack = 1'b0;
        n_checks++;
        if (req_ready !== 1'b1 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_recover: got ready=%b req=%b expected 1 0", req_ready, mem_req);
        end
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || busy !== 1'b0) seen = 1;
        end
        n_checks++;
        if (seen) begin
            n_fail++; $display("FAIL abort_no_rsp: got rsp_valid/busy after abort expected none");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got time limit expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_accesses();
        test_timeout();
        test_hold();
        test_reset_abort();
        test_accesses();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
